tick_rate_detector: RTL and testbench
=====================================

Name: tick_rate_detector

Overview:
- Receiver-side counterpart of the programmable clock-enable divider: consumes a single-cycle tick train on the system clock and recovers its interval in clock cycles.
- Maps a stable interval back to the 2-bit frequency code (100/1000/5000/20000 cycles).
- Sits after any tick source (local divider, or a synchronised external strobe). Reports lock, code and interval, and signals loss of lock.

Parameters:
- P0, 100, interval (cycles) for code 2'b00
- P1, 1000, interval for code 2'b01
- P2, 5000, interval for code 2'b10
- P3, 20000, interval for code 2'b11
- LOCK_COUNT, 4, consecutive equal intervals required to declare lock (1..15)
- TIMEOUT, 65535, cycles without a tick before returning to IDLE (must exceed P3)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- tick_in  input  1  single-cycle enable pulse, synchronous to clk
- locked  output  1  interval stable for LOCK_COUNT consecutive measurements
- period  output  32  locked interval in clk cycles; holds last locked value
- freq_code  output  2  code matching period; valid only when code_valid=1
- code_valid  output  1  locked and period equals one of P0..P3
- lost  output  1  one-cycle pulse when lock drops (mismatch or timeout)

Behaviour:
- Reset (asynchronous, any time, including mid-measurement):
  - State goes to IDLE.
  - All outputs are 0: locked, period, freq_code, code_valid, lost.
  - Internal cnt, last_interval and match_cnt are 0.
- Interval definition: number of clk cycles from one tick_in-high cycle to the next.
  - Back-to-back ticks give interval 1.
  - The divider at P0 gives exactly 100.
- cnt:
  - Loads 1 on every tick cycle; otherwise increments.
  - Saturates at TIMEOUT and never wraps.
  - On a tick, measured = cnt before the load.
- States:
  - IDLE: ignore everything but tick_in. On a tick, load cnt=1, set match_cnt=0, go to MEASURE.
  - MEASURE, on a tick:
    - If match_cnt=0 or measured!=last_interval: last_interval=measured, match_cnt=1.
    - Otherwise match_cnt++.
    - When the updated match_cnt equals LOCK_COUNT, go to LOCKED.
  - LOCKED, on a tick with measured==period: stay LOCKED, no output change.
  - LOCKED, on a tick with measured!=period: go to MEASURE, set last_interval=measured, match_cnt=1, locked=0, pulse lost.
  - MEASURE or LOCKED, when cnt reaches TIMEOUT with no tick: go to IDLE, match_cnt=0. If coming from LOCKED, pulse lost.
- Output timing: all outputs are registered.
  - On the transition into LOCKED: locked=1, period=last_interval, code/code_valid updated, all on the clock edge of the locking tick.
  - They are visible the cycle after that tick.
  - Latency to lock = LOCK_COUNT+1 ticks.
- Code mapping: exact compare of period against P0..P3.
  - No match: code_valid=0, freq_code=2'b00, locked still 1.
- On loss of lock:
  - locked and code_valid clear.
  - period and freq_code hold their last values.
  - lost is high for exactly one cycle.
- Simultaneous tick and timeout (cnt==TIMEOUT on a tick cycle): the tick wins. It is treated as a measurement with measured=TIMEOUT, which never matches P0..P3.
- tick_in held high continuously: interval 1 every cycle. Locks with period=1, code_valid=0.

Decomposition:
- Shared package (freq_pkg): state enum {IDLE, MEASURE, LOCKED}; the code-to-interval table P0..P3 as constants shared with the divider. The divider's period table is the single source of truth.
- One sub-module, tick_interval_counter:
  - 32-bit saturating counter with load-on-tick.
  - Outputs measured and timeout.
- The FSM and code mapping live in the top.

Test Plan:
- Divider at freq_set=00 driving tick_in, first tick at t0:
  - locked rises the cycle after tick 5 (t0+400).
  - period=100, freq_code=00, code_valid=1.
  - lost stays 0.
- Locked at 1000 (code 01), then switch source to code 11:
  - The first tick arriving after the switch gives a measured interval that does not match 1000.
  - Response: lost pulses exactly 1 cycle, locked=0, period holds 1000.
  - Relock with period=20000, code=11 after 4 further intervals of 20000.
- Ticks spaced 777 cycles: locked=1, period=777, code_valid=0, freq_code=00.
- Locked at 5000, then tick_in stuck low:
  - 65535 cycles after the last tick, lost pulses and state is IDLE.
  - The next tick restarts measurement, with no measurement taken on that tick.
- Intervals 100,100,100,101,100,100,100,100: no lock after the first three; locked rises after the 8th interval.
- Assert rst mid-MEASURE, and separately mid-LOCKED: all outputs go to 0 immediately (asynchronous). After release, the first tick only starts measurement.

Source files
------------

// File: rtl/tick_rate_detector_pkg.sv
// Shared definitions for the tick rate detector: FSM states and the code-to-interval table.
// The interval table mirrors the clock-enable divider's period table.
package tick_rate_detector_pkg;

  localparam int unsigned P0_CYCLES          = 100;
  localparam int unsigned P1_CYCLES          = 1000;
  localparam int unsigned P2_CYCLES          = 5000;
  localparam int unsigned P3_CYCLES          = 20000;
  localparam int unsigned DEFAULT_LOCK_COUNT = 4;
  localparam int unsigned DEFAULT_TIMEOUT    = 65535;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] code;
  } code_t;

  // Exact match of an interval against the table; no match reports code 00, invalid.
  function automatic code_t code_lookup(input logic [31:0] interval,
                                        input logic [31:0] p0, input logic [31:0] p1,
                                        input logic [31:0] p2, input logic [31:0] p3);
    code_t r;
    r = '{valid: 1'b0, code: 2'b00};
    if (interval == p0)      r = '{valid: 1'b1, code: 2'b00};
    else if (interval == p1) r = '{valid: 1'b1, code: 2'b01};
    else if (interval == p2) r = '{valid: 1'b1, code: 2'b10};
    else if (interval == p3) r = '{valid: 1'b1, code: 2'b11};
    return r;
  endfunction

endpackage

// File: rtl/tick_rate_detector_if.sv
// Tick input and lock/status outputs of the tick rate detector.
// master = tick source / status consumer, slave = detector.
interface tick_rate_detector_if;
  logic        tick_in;
  logic        locked;
  logic [31:0] period;
  logic [1:0]  freq_code;
  logic        code_valid;
  logic        lost;

  modport master (output tick_in, input locked, period, freq_code, code_valid, lost);
  modport slave  (input tick_in, output locked, period, freq_code, code_valid, lost);
endinterface

// File: rtl/tick_rate_detector_interval_counter.sv
// Saturating cycle counter reloaded with 1 on every tick; measured is the count before the reload.
// timeout flags the saturation value so the FSM can drop back to IDLE.
module tick_interval_counter #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  output logic [31:0] measured,
  output logic        timeout
);

  logic [31:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= 32'd1;
    end else if (cnt != 32'(TIMEOUT)) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign measured = cnt;
  assign timeout  = (cnt == 32'(TIMEOUT));

endmodule

// File: rtl/tick_rate_detector.sv
// Recovers the interval of a single-cycle tick train, declares lock after LOCK_COUNT equal
// intervals, maps the locked interval to a 2-bit frequency code and pulses lost on lock drop.
module tick_rate_detector
  import tick_rate_detector_pkg::*;
#(
  parameter int unsigned P0         = P0_CYCLES,
  parameter int unsigned P1         = P1_CYCLES,
  parameter int unsigned P2         = P2_CYCLES,
  parameter int unsigned P3         = P3_CYCLES,
  parameter int unsigned LOCK_COUNT = DEFAULT_LOCK_COUNT,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  tick_rate_detector_if.slave  bus
);

  logic [31:0] measured;
  logic        timeout;

  tick_interval_counter #(.TIMEOUT(TIMEOUT)) u_interval_counter (
    .clk      (clk),
    .rst      (rst),
    .tick     (bus.tick_in),
    .measured (measured),
    .timeout  (timeout)
  );

  state_t      state, state_n;
  logic [31:0] last_q, last_n;
  logic [3:0]  match_q, match_n;
  logic        locked_q, locked_n;
  logic [31:0] period_q, period_n;
  logic [1:0]  code_q, code_n;
  logic        valid_q, valid_n;
  logic        lost_q, lost_n;
  code_t       hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_q   <= '0;
      match_q  <= '0;
      locked_q <= 1'b0;
      period_q <= '0;
      code_q   <= 2'b00;
      valid_q  <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state    <= state_n;
      last_q   <= last_n;
      match_q  <= match_n;
      locked_q <= locked_n;
      period_q <= period_n;
      code_q   <= code_n;
      valid_q  <= valid_n;
      lost_q   <= lost_n;
    end
  end

  always_comb begin
    state_n  = state;
    last_n   = last_q;
    match_n  = match_q;
    locked_n = locked_q;
    period_n = period_q;
    code_n   = code_q;
    valid_n  = valid_q;
    lost_n   = 1'b0;
    hit      = '{valid: 1'b0, code: 2'b00};

    case (state)
      IDLE: begin
        if (bus.tick_in) begin
          match_n = '0;
          state_n = MEASURE;
        end
      end
      MEASURE: begin
        // A tick coinciding with timeout is still a measurement (measured == TIMEOUT).
        if (bus.tick_in) begin
          if (match_q == 4'd0 || measured != last_q) begin
            last_n  = measured;
            match_n = 4'd1;
          end else begin
            match_n = match_q + 4'd1;
          end
          if (match_n == 4'(LOCK_COUNT)) begin
            hit      = code_lookup(last_n, 32'(P0), 32'(P1), 32'(P2), 32'(P3));
            state_n  = LOCKED;
            locked_n = 1'b1;
            period_n = last_n;
            code_n   = hit.code;
            valid_n  = hit.valid;
          end
        end else if (timeout) begin
          state_n = IDLE;
          match_n = '0;
        end
      end
      LOCKED: begin
        if (bus.tick_in) begin
          if (measured != period_q) begin
            state_n  = MEASURE;
            last_n   = measured;
            match_n  = 4'd1;
            locked_n = 1'b0;
            valid_n  = 1'b0;
            lost_n   = 1'b1;
          end
        end else if (timeout) begin
          state_n  = IDLE;
          match_n  = '0;
          locked_n = 1'b0;
          valid_n  = 1'b0;
          lost_n   = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        match_n = '0;
      end
    endcase
  end

  assign bus.locked     = locked_q;
  assign bus.period     = period_q;
  assign bus.freq_code  = code_q;
  assign bus.code_valid = valid_q;
  assign bus.lost       = lost_q;

endmodule

// File: tb/tb_tick_rate_detector.sv
// Directed bench for tick_rate_detector with shortened P2/P3/TIMEOUT to keep runtime small.
module tb_tick_rate_detector;

  localparam int unsigned TP2 = 2500;
  localparam int unsigned TP3 = 3000;
  localparam int unsigned TTO = 8000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tick_rate_detector_if bus_if ();

  tick_rate_detector #(
    .P0(100), .P1(1000), .P2(TP2), .P3(TP3), .LOCK_COUNT(4), .TIMEOUT(TTO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int errors = 0;
  int checks = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tick();
    bus_if.tick_in = 1'b1;
    step();
    bus_if.tick_in = 1'b0;
  endtask

  // Wait so that the next send_tick lands iv cycles after the previous tick.
  task automatic gap(input int unsigned iv);
    repeat (iv - 1) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.tick_in = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    bus_if.tick_in = 1'b0;
    #2;
    checks++;
    if ({bus_if.locked, bus_if.period, bus_if.freq_code, bus_if.code_valid, bus_if.lost} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs locked=%0b period=%0d code=%0d valid=%0b lost=%0b expected all 0",
               bus_if.locked, bus_if.period, bus_if.freq_code, bus_if.code_valid, bus_if.lost);
    end
  endtask

  task automatic test_lock_p0();
    do_reset();
    send_tick();
    repeat (3) begin gap(100); send_tick(); end
    gap(100);
    checks++;
    if (bus_if.locked !== 1'b0) begin errors++; $display("FAIL p0_prelock locked=%0b expected 0", bus_if.locked); end
    send_tick();
    checks++;
    if (bus_if.locked !== 1'b1) begin errors++; $display("FAIL p0_locked locked=%0b expected 1", bus_if.locked); end
    checks++;
    if (bus_if.period !== 32'd100) begin errors++; $display("FAIL p0_period period=%0d expected 100", bus_if.period); end
    checks++;
    if ({bus_if.code_valid, bus_if.freq_code} !== 3'b100) begin
      errors++; $display("FAIL p0_code valid=%0b code=%0d expected 1/0", bus_if.code_valid, bus_if.freq_code);
    end
    step();
    checks++;
    if (bus_if.lost !== 1'b0 || bus_if.locked !== 1'b1) begin
      errors++; $display("FAIL p0_steady lost=%0b locked=%0b expected 0/1", bus_if.lost, bus_if.locked);
    end
  endtask

  task automatic test_switch();
    do_reset();
    send_tick();
    repeat (4) begin gap(1000); send_tick(); end
    checks++;
    if ({bus_if.locked, bus_if.code_valid, bus_if.freq_code} !== 4'b1101 || bus_if.period !== 32'd1000) begin
      errors++; $display("FAIL p1_lock locked=%0b valid=%0b code=%0d period=%0d expected 1/1/1/1000",
                         bus_if.locked, bus_if.code_valid, bus_if.freq_code, bus_if.period);
    end
    // Divider switched mid-interval: the first tick after the switch arrives early.
    gap(1700);
    send_tick();
    checks++;
    if (bus_if.lost !== 1'b1 || bus_if.locked !== 1'b0 || bus_if.code_valid !== 1'b0) begin
      errors++; $display("FAIL switch_lost lost=%0b locked=%0b valid=%0b expected 1/0/0",
                         bus_if.lost, bus_if.locked, bus_if.code_valid);
    end
    checks++;
    if (bus_if.period !== 32'd1000 || bus_if.freq_code !== 2'b01) begin
      errors++; $display("FAIL switch_hold period=%0d code=%0d expected 1000/1", bus_if.period, bus_if.freq_code);
    end
    step();
    checks++;
    if (bus_if.lost !== 1'b0) begin errors++; $display("FAIL switch_lost_width lost=%0b expected 0", bus_if.lost); end
    repeat (TP3 - 2) step();
    send_tick();
    repeat (2) begin gap(TP3); send_tick(); end
    gap(TP3);
    checks++;
    if (bus_if.locked !== 1'b0) begin errors++; $display("FAIL p3_prelock locked=%0b expected 0", bus_if.locked); end
    send_tick();
    checks++;
    if ({bus_if.locked, bus_if.code_valid, bus_if.freq_code} !== 4'b1111 || bus_if.period !== TP3) begin
      errors++; $display("FAIL p3_relock locked=%0b valid=%0b code=%0d period=%0d expected 1/1/3/%0d",
                         bus_if.locked, bus_if.code_valid, bus_if.freq_code, bus_if.period, TP3);
    end
  endtask

  task automatic test_non_table();
    // Continues from lock at TP3 with code 11.
    gap(777);
    send_tick();
    checks++;
    if (bus_if.lost !== 1'b1) begin errors++; $display("FAIL nt_lost lost=%0b expected 1", bus_if.lost); end
    repeat (2) begin gap(777); send_tick(); end
    gap(777);
    checks++;
    if (bus_if.locked !== 1'b0) begin errors++; $display("FAIL nt_prelock locked=%0b expected 0", bus_if.locked); end
    send_tick();
    checks++;
    if ({bus_if.locked, bus_if.code_valid, bus_if.freq_code} !== 4'b1000 || bus_if.period !== 32'd777) begin
      errors++; $display("FAIL nt_lock locked=%0b valid=%0b code=%0d period=%0d expected 1/0/0/777",
                         bus_if.locked, bus_if.code_valid, bus_if.freq_code, bus_if.period);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_tick();
    repeat (4) begin gap(TP2); send_tick(); end
    checks++;
    if ({bus_if.locked, bus_if.code_valid, bus_if.freq_code} !== 4'b1110 || bus_if.period !== TP2) begin
      errors++; $display("FAIL p2_lock locked=%0b valid=%0b code=%0d period=%0d expected 1/1/2/%0d",
                         bus_if.locked, bus_if.code_valid, bus_if.freq_code, bus_if.period, TP2);
    end
    repeat (TTO - 1) step();
    checks++;
    if (bus_if.lost !== 1'b0 || bus_if.locked !== 1'b1) begin
      errors++; $display("FAIL to_early lost=%0b locked=%0b expected 0/1", bus_if.lost, bus_if.locked);
    end
    step();
    checks++;
    if (bus_if.lost !== 1'b1 || bus_if.locked !== 1'b0 || bus_if.code_valid !== 1'b0) begin
      errors++; $display("FAIL to_lost lost=%0b locked=%0b valid=%0b expected 1/0/0",
                         bus_if.lost, bus_if.locked, bus_if.code_valid);
    end
    checks++;
    if (bus_if.period !== TP2 || bus_if.freq_code !== 2'b10) begin
      errors++; $display("FAIL to_hold period=%0d code=%0d expected %0d/2", bus_if.period, bus_if.freq_code, TP2);
    end
    step();
    checks++;
    if (bus_if.lost !== 1'b0) begin errors++; $display("FAIL to_lost_width lost=%0b expected 0", bus_if.lost); end
    repeat (50) step();
    send_tick();
    repeat (3) begin gap(100); send_tick(); end
    gap(100);
    checks++;
    if (bus_if.locked !== 1'b0) begin errors++; $display("FAIL to_restart_prelock locked=%0b expected 0", bus_if.locked); end
    send_tick();
    checks++;
    if (bus_if.locked !== 1'b1 || bus_if.period !== 32'd100 || bus_if.freq_code !== 2'b00) begin
      errors++; $display("FAIL to_restart_lock locked=%0b period=%0d code=%0d expected 1/100/0",
                         bus_if.locked, bus_if.period, bus_if.freq_code);
    end
  endtask

  task automatic test_glitch();
    int unsigned ivs [8] = '{100, 100, 100, 101, 100, 100, 100, 100};
    do_reset();
    send_tick();
    for (int i = 0; i < 8; i++) begin
      gap(ivs[i]);
      send_tick();
      checks++;
      if (bus_if.locked !== ((i == 7) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL glitch_iv%0d locked=%0b expected %0b", i, bus_if.locked, (i == 7));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_tick();
    gap(100);
    send_tick();
    repeat (50) step();
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({bus_if.locked, bus_if.period, bus_if.freq_code, bus_if.code_valid, bus_if.lost} !== 37'd0) begin
      errors++; $display("FAIL rst_measure outputs locked=%0b period=%0d expected all 0", bus_if.locked, bus_if.period);
    end
    step();
    rst = 1'b0;
    step();
    send_tick();
    repeat (4) begin gap(100); send_tick(); end
    checks++;
    if (bus_if.locked !== 1'b1 || bus_if.period !== 32'd100) begin
      errors++; $display("FAIL rst_relock locked=%0b period=%0d expected 1/100", bus_if.locked, bus_if.period);
    end
    repeat (20) step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus_if.locked, bus_if.period, bus_if.freq_code, bus_if.code_valid, bus_if.lost} !== 37'd0) begin
      errors++; $display("FAIL rst_locked outputs locked=%0b period=%0d valid=%0b expected all 0",
                         bus_if.locked, bus_if.period, bus_if.code_valid);
    end
    step();
    rst = 1'b0;
    step();
    send_tick();
    repeat (3) begin gap(100); send_tick(); end
    gap(100);
    checks++;
    if (bus_if.locked !== 1'b0) begin errors++; $display("FAIL rst_after_prelock locked=%0b expected 0", bus_if.locked); end
    send_tick();
    checks++;
    if (bus_if.locked !== 1'b1) begin errors++; $display("FAIL rst_after_lock locked=%0b expected 1", bus_if.locked); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus_if.tick_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (bus_if.locked !== ((k == 5) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL b2b_step%0d locked=%0b expected %0b", k, bus_if.locked, (k == 5));
      end
    end
    checks++;
    if (bus_if.period !== 32'd1 || bus_if.code_valid !== 1'b0 || bus_if.freq_code !== 2'b00) begin
      errors++; $display("FAIL b2b_value period=%0d valid=%0b code=%0d expected 1/0/0",
                         bus_if.period, bus_if.code_valid, bus_if.freq_code);
    end
    step();
    checks++;
    if (bus_if.locked !== 1'b1 || bus_if.lost !== 1'b0) begin
      errors++; $display("FAIL b2b_hold locked=%0b lost=%0b expected 1/0", bus_if.locked, bus_if.lost);
    end
    bus_if.tick_in = 1'b0;
  endtask

  initial begin
    bus_if.tick_in = 1'b0;
    test_reset();
    test_lock_p0();
    test_switch();
    test_non_table();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
